// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with valid/ready handshakes and a synchronous flush.
module mdu_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         busy
);

    localparam int CW = $clog2(N) + 1;
    // W ops only differ from full-width ops when the datapath is wider than 32 bits.
    localparam bit WIDE = (N > 32);
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic            w_q, w_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    opnd_q, opnd_d;
    logic [N-1:0]    result_q, result_d;

    function automatic logic [N-1:0] sext32(input logic [31:0] x);
        return N'($signed(x));
    endfunction

    function automatic logic f_is_mul(input logic [3:0] o);
        return (o <= 4'd3) || (o == 4'd8);
    endfunction

    function automatic logic f_is_rem(input logic [3:0] o);
        return (o == 4'd6) || (o == 4'd7) || (o == 4'd11) || (o == 4'd12);
    endfunction

    function automatic logic f_sa(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd2) || (o == 4'd4) || (o == 4'd6) ||
               (o == 4'd9) || (o == 4'd11);
    endfunction

    function automatic logic f_sb(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd4) || (o == 4'd6) || (o == 4'd9) || (o == 4'd11);
    endfunction

    // Request decode and operand preparation
    logic         w_in, mul_in, rem_in, rsv_in, div_in;
    logic [N-1:0] a_ext, b_ext, a_sx, mag_a, mag_b, fast_res;
    logic         sign_a, sign_b, div_zero, ovf, fast, res_neg;

    always_comb begin
        rsv_in   = (op >= 4'd13);
        mul_in   = f_is_mul(op);
        rem_in   = f_is_rem(op);
        div_in   = !mul_in && !rsv_in;
        w_in     = WIDE && (op >= 4'd8) && !rsv_in;
        a_sx     = w_in ? sext32(a[31:0]) : a;
        a_ext    = w_in ? (f_sa(op) ? sext32(a[31:0]) : {{(N-32){1'b0}}, a[31:0]}) : a;
        b_ext    = w_in ? (f_sb(op) ? sext32(b[31:0]) : {{(N-32){1'b0}}, b[31:0]}) : b;
        sign_a   = f_sa(op) && a_ext[N-1];
        sign_b   = f_sb(op) && b_ext[N-1];
        mag_a    = sign_a ? -a_ext : a_ext;
        mag_b    = sign_b ? -b_ext : b_ext;
        res_neg  = rem_in ? sign_a : (sign_a ^ sign_b);
        div_zero = (b_ext == '0);
        ovf      = div_in && f_sb(op) &&
                   (w_in ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                         : ((a == MINV) && (b == '1)));
        fast     = rsv_in || (div_in && (div_zero || ovf));
        fast_res = '0;
        if (rsv_in)        fast_res = '0;
        else if (div_zero) fast_res = rem_in ? a_sx : '1;
        else if (ovf)      fast_res = rem_in ? '0 : a_sx;
    end

    // One iteration step of each datapath
    logic [N:0]     sum, shifted, diff;
    logic           ge;
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   q_s, r_s, dv, fix_res;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[N-1]};
        diff    = shifted - {1'b0, opnd_q};
        ge      = !diff[N];
        prod_s  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_s     = neg_q ? -lo_q : lo_q;
        r_s     = neg_q ? -hi_q : hi_q;
        dv      = f_is_rem(op_q) ? r_s : q_s;
        if (op_q == 4'd0)
            fix_res = prod_s[N-1:0];
        else if (op_q == 4'd8)
            fix_res = sext32(prod_s[N-1 -: 32]);
        else if (f_is_mul(op_q))
            fix_res = prod_s[2*N-1:N];
        else
            fix_res = w_q ? sext32(dv[31:0]) : dv;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        w_d      = w_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    w_d   = w_in;
                    neg_d = res_neg;
                    if (fast) begin
                        state_d  = DONE;
                        result_d = fast_res;
                    end else begin
                        state_d = CALC;
                        cnt_d   = w_in ? CW'(31) : CW'(N - 1);
                        hi_d    = '0;
                        if (mul_in) begin
                            lo_d   = mag_b;
                            opnd_d = mag_a;
                        end else begin
                            // Align a 32-bit dividend to the top so the same K-step shift works.
                            lo_d   = w_in ? (mag_a << (N - 32)) : mag_a;
                            opnd_d = mag_b;
                        end
                    end
                end
            end
            CALC: begin
                if (f_is_mul(op_q)) begin
                    hi_d = sum[N:1];
                    lo_d = {sum[0], lo_q[N-1:1]};
                end else begin
                    hi_d = ge ? diff[N-1:0] : shifted[N-1:0];
                    lo_d = {lo_q[N-2:0], ge};
                end
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                result_d = fix_res;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= IDLE;
            op_q     <= '0;
            w_q      <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            w_q      <= w_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (N=64): scoreboard queue of expected results,
// latency, handshake, back-pressure and kill checks.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [3:0]  op;
    logic [63:0] a, b, out_result;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    mdu_iter #(.N(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns once the first cycle after the accept edge is reached.
    task automatic issue(input logic [3:0] o, input logic [63:0] av, input logic [63:0] bv);
        @(negedge clk);
        chk("in_ready before issue", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        in_valid = 1'b0; op = 4'd0; a = 64'h0; b = 64'h0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] av,
                          input logic [63:0] bv, input logic [63:0] exp, input int lat);
        int  cyc;
        bit  rdy_seen;
        logic [63:0] e;
        sb_q.push_back(exp);
        issue(o, av, bv);
        cyc = 1;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (in_ready) rdy_seen = 1'b1;
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " in_ready low while busy"}, 64'(rdy_seen), 64'd0);
        e = sb_q.pop_front();
        chk({tag, " result"}, out_result, e);
        $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d",
                 o, av, bv, out_result, e, cyc);
        if (out_ready) begin
            @(negedge clk);
            chk({tag, " out_valid drops"}, 64'(out_valid), 64'd0);
            chk({tag, " back to idle"}, 64'(in_ready), 64'd1);
        end
    endtask

    task automatic kill_test(input string tag, input bit use_rst);
        bit seen;
        issue(4'd5, 64'd1000, 64'd3);
        repeat (9) @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " out_result cleared"}, out_result, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk({tag, " no result"}, 64'(seen), 64'd0);
        $display("%s: killed DIVU, in_ready=%0d busy=%0d out_valid_seen=%0d", tag, in_ready, busy, seen);
        run_op({tag, " DIVU after"}, 4'd5, 64'd100, 64'd7, 64'd14, 66);
    endtask

    initial begin
        logic [63:0] held;
        bit          bp_ok;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; a = 64'h0; b = 64'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_result", out_result, 64'd0);

        run_op("MUL", 4'd0, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0001_FFFF_FFFE, 66);
        run_op("MULH", 4'd1, '1, '1, 64'd0, 66);
        run_op("MULHU", 4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("MULHSU", 4'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);

        run_op("DIV by zero", 4'd4, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("REM by zero", 4'd6, 64'd7, 64'd0, 64'd7, 1);
        run_op("DIV overflow", 4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("REM overflow", 4'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("reserved", 4'd13, 64'd5, 64'd3, 64'd0, 1);

        run_op("DIV neg", 4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 66);
        run_op("REM neg", 4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66);

        run_op("DIVW", 4'd9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("REMW", 4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("DIVUW", 4'd10, 64'h1234_5678_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34);

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        run_op("MULW", 4'd8, 64'd3, 64'd5, 64'd15, 34);
        held = 64'd15;
        bp_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 4'd0; a = 64'd9; b = 64'd9;
            @(negedge clk);
            if (!out_valid || out_result !== held || in_ready) bp_ok = 1'b0;
        end
        chk("backpressure hold", 64'(bp_ok), 64'd1);
        chk("backpressure result", out_result, held);
        $display("backpressure: out_valid=%0d out_result=%h in_ready=%0d", out_valid, out_result, in_ready);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("backpressure release out_valid", 64'(out_valid), 64'd0);
        chk("backpressure release busy", 64'(busy), 64'd0);
        chk("backpressure release in_ready", 64'(in_ready), 64'd1);

        kill_test("flush", 1'b0);
        kill_test("rst", 1'b1);

        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
